// File: rtl/keypad_matrix_scanner.sv
// keypad_matrix_scanner
//   Scans a 3x4 phone-style key matrix (columns driven, rows sensed),
//   debounces complete scan frames and reports single-key presses as a
//   one-hot 12-bit code with a one-cycle valid pulse.
//
// Ports:
//   clk        system clock
//   rst        synchronous active-high reset
//   row_in     [3:0]  matrix rows, active-high, asynchronous to clk
//                     row0 = (1,2,3) ... row3 = (*,0,#)
//   col_out    [2:0]  one-hot column strobe; col0=(1,4,7,*), col1=(2,5,8,0),
//                     col2=(3,6,9,#)
//   key_code   [11:0] one-hot code of the last accepted key
//   key_valid         one-cycle pulse when a new key is accepted
//   key_held          high while the accepted frame holds a single key
module keypad_matrix_scanner #(
  parameter int unsigned SCAN_DIV     = 4,
  parameter int unsigned DEBOUNCE_CNT = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  row_in,
  output logic [2:0]  col_out,
  output logic [11:0] key_code,
  output logic        key_valid,
  output logic        key_held
);

  localparam int unsigned DW = $clog2(SCAN_DIV);
  // One extra count value so DEBOUNCE_CNT itself is representable.
  localparam int unsigned SW = $clog2(DEBOUNCE_CNT + 1);
  localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
  localparam logic [SW-1:0] STABLE_MAX = SW'(DEBOUNCE_CNT);

  typedef enum logic [2:0] {
    COL0 = 3'b001,
    COL1 = 3'b010,
    COL2 = 3'b100
  } col_e;

  col_e            r_col;
  logic [DW-1:0]   r_dwell;
  logic [3:0]      r_sync1;
  logic [3:0]      r_sync2;
  logic [11:0]     r_frame;
  logic [11:0]     r_prev;
  logic [11:0]     r_accepted;
  logic [SW-1:0]   r_stable;
  logic [11:0]     r_key_code;
  logic            r_key_valid;
  logic            r_key_held;

  logic            w_sample;
  logic [11:0]     w_col_bits;
  logic [11:0]     w_full;
  logic [11:0]     w_vframe;
  logic [SW-1:0]   w_stable_next;
  logic            w_accept;

  assign w_sample = (r_dwell == DWELL_LAST);

  // Map the synchronized rows of the active column onto key-code bits.
  // Row 3 is irregular: '*'=bit10, '0'=bit9, '#'=bit11.
  always_comb begin
    w_col_bits = '0;
    case (r_col)
      COL0: begin
        w_col_bits[0]  = r_sync2[0];
        w_col_bits[3]  = r_sync2[1];
        w_col_bits[6]  = r_sync2[2];
        w_col_bits[10] = r_sync2[3];
      end
      COL1: begin
        w_col_bits[1]  = r_sync2[0];
        w_col_bits[4]  = r_sync2[1];
        w_col_bits[7]  = r_sync2[2];
        w_col_bits[9]  = r_sync2[3];
      end
      COL2: begin
        w_col_bits[2]  = r_sync2[0];
        w_col_bits[5]  = r_sync2[1];
        w_col_bits[8]  = r_sync2[2];
        w_col_bits[11] = r_sync2[3];
      end
      default: w_col_bits = '0;
    endcase
  end

  assign w_full   = r_frame | w_col_bits;
  // Anything other than exactly one key reads as "no key".
  assign w_vframe = $onehot(w_full) ? w_full : '0;

  always_comb begin
    w_stable_next = SW'(1);
    if (w_vframe == r_prev) begin
      w_stable_next = (r_stable == STABLE_MAX) ? r_stable : r_stable + 1'b1;
    end
  end

  assign w_accept = (w_stable_next == STABLE_MAX) && (w_vframe != r_accepted);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_col       <= COL0;
      r_dwell     <= '0;
      r_sync1     <= '0;
      r_sync2     <= '0;
      r_frame     <= '0;
      r_prev      <= '0;
      r_accepted  <= '0;
      r_stable    <= '0;
      r_key_code  <= '0;
      r_key_valid <= 1'b0;
      r_key_held  <= 1'b0;
    end else begin
      r_sync1     <= row_in;
      r_sync2     <= r_sync1;
      r_key_valid <= 1'b0;
      if (w_sample) begin
        r_dwell <= '0;
        case (r_col)
          COL0: begin
            r_col   <= COL1;
            r_frame <= w_full;
          end
          COL1: begin
            r_col   <= COL2;
            r_frame <= w_full;
          end
          default: begin
            // col2 sample completes the frame: run debounce on it.
            r_col    <= COL0;
            r_frame  <= '0;
            r_prev   <= w_vframe;
            r_stable <= w_stable_next;
            if (w_accept) begin
              r_accepted <= w_vframe;
              r_key_held <= (w_vframe != '0);
              if (w_vframe != '0) begin
                r_key_code  <= w_vframe;
                r_key_valid <= 1'b1;
              end
            end
          end
        endcase
      end else begin
        r_dwell <= r_dwell + 1'b1;
      end
    end
  end

  assign col_out   = r_col;
  assign key_code  = r_key_code;
  assign key_valid = r_key_valid;
  assign key_held  = r_key_held;

endmodule
